// File: rtl/imem_loader_if.sv
// Byte stream, instruction-memory write port and status of the imem loader.
interface imem_loader_if #(
  parameter int ADDR_W = 8
);
  logic              start;
  logic [7:0]        byte_i;
  logic              byte_valid_i;
  logic              byte_ready_o;
  logic              mem_we_o;
  logic [31:0]       mem_addr_o;
  logic [31:0]       mem_wd_o;
  logic              cpu_rst_o;
  logic              busy_o;
  logic              done_o;
  logic              err_o;
  logic [ADDR_W:0]   word_count_o;

  modport master (
    input  start, byte_i, byte_valid_i,
    output byte_ready_o, mem_we_o, mem_addr_o, mem_wd_o,
    output cpu_rst_o, busy_o, done_o, err_o, word_count_o
  );

  modport slave (
    output start, byte_i, byte_valid_i,
    input  byte_ready_o, mem_we_o, mem_addr_o, mem_wd_o,
    input  cpu_rst_o, busy_o, done_o, err_o, word_count_o
  );
endinterface

// File: rtl/imem_loader.sv
// Instruction-memory programmer: length header, LE words, XOR checksum.
module imem_loader #(
  parameter int ADDR_W = 8
) (
  input  logic          clk,
  input  logic          rst,
  imem_loader_if.master bus
);
  localparam int DEPTH = 2**ADDR_W;

  typedef enum logic [2:0] {
    IDLE, LEN, DATA, WRITE, CHECK, DONE, ERR
  } state_t;

  state_t            state;
  state_t            nxt;
  logic [1:0]        cnt;
  logic [15:0]       n;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W:0]   wcnt;
  logic [7:0]        chk;
  logic [23:0]       word;
  logic              acc;
  logic              restart;
  logic [15:0]       nlen;

  assign acc     = bus.byte_valid_i & bus.byte_ready_o;
  assign nlen    = {bus.byte_i, n[7:0]};
  assign restart = bus.start &
                   (state == IDLE || state == DONE || state == ERR);
  assign bus.word_count_o = wcnt;

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE, DONE, ERR: if (bus.start) nxt = LEN;
      LEN: if (acc && cnt[0]) begin
        if (nlen == '0)              nxt = CHECK;
        else if (32'(nlen) > DEPTH)  nxt = ERR;
        else                         nxt = DATA;
      end
      DATA:  if (acc && cnt == 2'd3) nxt = WRITE;
      WRITE: nxt = (32'(wcnt) + 1 == 32'(n)) ? CHECK : DATA;
      CHECK: if (acc) nxt = (bus.byte_i == chk) ? DONE : ERR;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      cnt              <= '0;
      n                <= '0;
      idx              <= '0;
      wcnt             <= '0;
      chk              <= '0;
      word             <= '0;
      bus.byte_ready_o <= 1'b0;
      bus.busy_o       <= 1'b0;
      bus.done_o       <= 1'b0;
      bus.err_o        <= 1'b0;
      bus.cpu_rst_o    <= 1'b1;
      bus.mem_we_o     <= 1'b0;
      bus.mem_addr_o   <= '0;
      bus.mem_wd_o     <= '0;
    end else begin
      state            <= nxt;
      bus.byte_ready_o <= nxt inside {LEN, DATA, CHECK};
      bus.busy_o       <= nxt inside {LEN, DATA, WRITE, CHECK};
      bus.done_o       <= nxt == DONE;
      bus.err_o        <= nxt == ERR;
      bus.cpu_rst_o    <= nxt != DONE;
      bus.mem_we_o     <= nxt == WRITE;
      if (restart) begin
        cnt  <= '0;
        idx  <= '0;
        wcnt <= '0;
        chk  <= '0;
      end
      if (acc) chk <= chk ^ bus.byte_i;
      if (state == LEN && acc) begin
        if (cnt[0]) n[15:8] <= bus.byte_i;
        else        n[7:0]  <= bus.byte_i;
        cnt <= {1'b0, ~cnt[0]};
      end
      if (state == DATA && acc) begin
        cnt <= cnt + 2'd1;
        // the 4th byte goes straight to the write port
        unique case (cnt)
          2'd0: word[7:0]   <= bus.byte_i;
          2'd1: word[15:8]  <= bus.byte_i;
          2'd2: word[23:16] <= bus.byte_i;
          2'd3: begin
            bus.mem_addr_o <= {{(30-ADDR_W){1'b0}}, idx, 2'b00};
            bus.mem_wd_o   <= {bus.byte_i, word};
          end
          default: ;
        endcase
      end
      if (state == WRITE) begin
        idx  <= idx + 1'b1;
        wcnt <= wcnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader.
module tb_imem_loader;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 2**ADDR_W;

  logic clk = 1'b0;
  logic rst = 1'b1;

  imem_loader_if #(.ADDR_W(ADDR_W)) bus();
  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int t_load;
  bit noise = 1'b0;
  logic [7:0]  last_ck;
  logic [31:0] wq[$];
  logic [63:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Per-cycle checks: write port against the expected write list,
  // plus the status relations that must hold in every state.
  always @(negedge clk) begin : cmp
    logic [63:0] e;
    if (!rst) begin
      chk("cpu_rst_vs_done", 32'(bus.cpu_rst_o), 32'(!bus.done_o));
      chk("ready_wo_busy", 32'(bus.byte_ready_o & !bus.busy_o), 0);
      chk("done_and_err", 32'(bus.done_o & bus.err_o), 0);
      if (bus.mem_we_o) begin
        chk("we_with_ready", 32'(bus.byte_ready_o), 0);
        if (exp_q.size() == 0) begin
          chk("unexpected_write", bus.mem_addr_o, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("mem_addr", bus.mem_addr_o, e[63:32]);
          chk("mem_wd", bus.mem_wd_o, e[31:0]);
        end
      end
    end
  end

  task automatic reset_chk();
    chk("rst_cpu_rst", 32'(bus.cpu_rst_o), 1);
    chk("rst_ready", 32'(bus.byte_ready_o), 0);
    chk("rst_we", 32'(bus.mem_we_o), 0);
    chk("rst_busy", 32'(bus.busy_o), 0);
    chk("rst_done", 32'(bus.done_o), 0);
    chk("rst_err", 32'(bus.err_o), 0);
    chk("rst_addr", bus.mem_addr_o, 0);
    chk("rst_wd", bus.mem_wd_o, 0);
    chk("rst_wc", 32'(bus.word_count_o), 0);
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gapmax);
    int g;
    g = (gapmax > 0) ? int'($urandom_range(gapmax, 0)) : 0;
    repeat (g) begin
      bus.byte_valid_i = 1'b0;
      bus.start = noise && ($urandom_range(1, 0) == 1);
      @(negedge clk);
    end
    bus.byte_valid_i = 1'b1;
    bus.byte_i = b;
    for (int t = 0; t < 64; t++) begin
      bus.start = noise && ($urandom_range(1, 0) == 1);
      if (bus.byte_ready_o) begin
        @(negedge clk);
        bus.byte_valid_i = 1'b0;
        bus.start = 1'b0;
        return;
      end
      @(negedge clk);
    end
    bus.byte_valid_i = 1'b0;
    bus.start = 1'b0;
    chk("byte_accept_timeout", 32'(b), 32'hFFFF_FFFF);
  endtask

  // Builds the stream for n words from wq, sets up the expected writes,
  // drives it and checks the end-of-load status.
  task automatic run_load(input int n, input bit bad, input int gapmax);
    logic [7:0] s[$];
    logic [7:0] x;
    int c0;
    bit good;
    x = 8'h00;
    exp_q.delete();
    s.push_back(n[7:0]);
    s.push_back(n[15:8]);
    if (n <= DEPTH) begin
      for (int i = 0; i < n; i++) begin
        for (int k = 0; k < 4; k++) s.push_back(wq[i][8*k +: 8]);
        exp_q.push_back({32'(i*4), wq[i]});
      end
      foreach (s[j]) x ^= s[j];
      last_ck = bad ? ~x : x;
      s.push_back(last_ck);
    end
    c0 = cyc;
    pulse_start();
    foreach (s[j]) send_byte(s[j], gapmax);
    t_load = cyc - c0;
    good = (n <= DEPTH) && !bad;
    chk("end_done", 32'(bus.done_o), 32'(good));
    chk("end_err", 32'(bus.err_o), 32'(!good));
    chk("end_cpu_rst", 32'(bus.cpu_rst_o), 32'(!good));
    chk("end_busy", 32'(bus.busy_o), 0);
    chk("end_ready", 32'(bus.byte_ready_o), 0);
    chk("end_wc", 32'(bus.word_count_o), (n <= DEPTH) ? 32'(n) : 0);
    chk("writes_missing", 32'(exp_q.size()), 0);
    if (gapmax == 0 && !noise)
      chk("load_time", 32'(t_load),
          (n <= DEPTH) ? 32'(4 + 5*n) : 32'd3);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.start = 1'b0;
    bus.byte_valid_i = 1'b0;
    bus.byte_i = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    reset_chk();
    @(negedge clk);

    wq = '{32'h1234_5678};
    run_load(1, 1'b0, 0);
    chk("model_ck_1word", 32'(last_ck), 32'h09);

    wq = '{32'hDEAD_BEEF, 32'h0000_0013};
    run_load(2, 1'b0, 3);
    chk("model_ck_2word", 32'(last_ck), 32'h33);

    run_load(0, 1'b0, 0);
    chk("n0_time", 32'(t_load), 4);

    run_load(257, 1'b0, 0);

    wq = '{32'h1234_5678};
    run_load(1, 1'b1, 0);
    chk("model_ck_bad", 32'(last_ck), 32'hF6);
    wq = '{32'hCAFE_F00D, 32'h0000_0093, 32'h0010_0073};
    run_load(3, 1'b0, 2);

    // reset after the 2nd data byte of the first word
    exp_q.delete();
    pulse_start();
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'h78, 0);
    send_byte(8'h56, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    reset_chk();
    repeat (6) @(negedge clk);
    chk("post_rst_idle_busy", 32'(bus.busy_o), 0);

    noise = 1'b1;
    for (int it = 0; it < 20; it++) begin
      n = int'($urandom_range(6, 0));
      wq.delete();
      for (int i = 0; i < n; i++) wq.push_back($urandom);
      run_load(n, $urandom_range(3, 0) == 0, 3);
    end
    noise = 1'b0;

    wq.delete();
    for (int i = 0; i < DEPTH; i++) wq.push_back($urandom);
    run_load(DEPTH, 1'b0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
